// File: rtl/tcdm_pkg.sv
// tcdm_pkg: shared defaults and index-width helper for the TCDM request mux
package tcdm_pkg;
  localparam int NUM_INPUTS_DEF = 4;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tcdm_idx_fifo.sv
// tcdm_idx_fifo: synchronous FIFO of master indices awaiting read responses
module tcdm_idx_fifo import tcdm_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = idx_w(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rp];
  always_ff @(posedge clk_i)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/tcdm_req_mux.sv
// tcdm_req_mux: round-robin N:1 TCDM request mux tracking read-response owners.
// Define TCDM_REQ_MUX_LOCK_EN to hold a stalled winner until it is accepted.
module tcdm_req_mux import tcdm_pkg::*; #(
  parameter int NUM_INPUTS      = NUM_INPUTS_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  localparam int IW = idx_w(NUM_INPUTS),
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_INPUTS-1:0] req_i,
  output logic [NUM_INPUTS-1:0] gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i [NUM_INPUTS],
  input  logic                  wen_i [NUM_INPUTS],
  input  logic [DATA_WIDTH-1:0] wdata_i [NUM_INPUTS],
  input  logic [BW-1:0]         be_i [NUM_INPUTS],
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  wen_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BW-1:0]         be_o,
  output logic [IW-1:0]         master_idx_o,
  input  logic                  rvalid_i,
  input  logic                  rready_i,
  output logic [IW-1:0]         resp_master_idx_o,
  output logic                  resp_idx_valid_o
);
  logic [IW-1:0] rr_ptr, win, cand;
  logic [NUM_INPUTS-1:0] elig;
  logic found, full, empty;
`ifdef TCDM_REQ_MUX_LOCK_EN
  logic locked;
  logic [IW-1:0] lock_idx;
`endif
  // a read may only win while the FIFO has room to record its owner
  always_comb
    for (int i = 0; i < NUM_INPUTS; i++) elig[i] = req_i[i] & (wen_i[i] | ~full);
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = rr_ptr + IW'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`ifdef TCDM_REQ_MUX_LOCK_EN
    if (locked && elig[lock_idx]) win = lock_idx;
`endif
  end
  always_comb begin
    req_o        = found;
    addr_o       = found ? addr_i[win] : '0;
    wen_o        = found ? wen_i[win] : 1'b0;
    wdata_o      = found ? wdata_i[win] : '0;
    be_o         = found ? be_i[win] : '0;
    master_idx_o = found ? win : '0;
    gnt_o        = '0;
    gnt_o[win]   = gnt_i & found;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr <= '0;
    else if (req_o && gnt_i) rr_ptr <= win + IW'(1);
  end
`ifdef TCDM_REQ_MUX_LOCK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      locked   <= req_o & ~gnt_i;
      lock_idx <= win;
    end
  end
`endif
  tcdm_idx_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (req_o & gnt_i & ~wen_o),
    .pop   (rvalid_i & rready_i),
    .din   (win),
    .full  (full),
    .empty (empty),
    .head  (resp_master_idx_o)
  );
  assign resp_idx_valid_o = ~empty;
endmodule

// File: tb/tb_tcdm_req_mux.sv
// tb_tcdm_req_mux: directed self-checking bench for tcdm_req_mux (default 4 masters)
module tb_tcdm_req_mux;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req, gnt;
  logic [31:0] addr [4];
  logic wen [4];
  logic [31:0] wdata [4];
  logic [3:0] be [4];
  logic req_o, gnt_i, wen_o, rvalid, rready, rvld;
  logic [31:0] addr_o, wdata_o;
  logic [3:0] be_o;
  logic [1:0] midx, ridx;
  int checks = 0, failures = 0;

  tcdm_req_mux dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .addr_i(addr), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wen_o(wen_o),
    .wdata_o(wdata_o), .be_o(be_o), .master_idx_o(midx),
    .rvalid_i(rvalid), .rready_i(rready),
    .resp_master_idx_o(ridx), .resp_idx_valid_o(rvld)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks += 4;
    if (req_o !== 1'b0) begin failures++; $display("FAIL reset_req_o got=%b exp=0", req_o); end
    if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    if (rvld !== 1'b0) begin failures++; $display("FAIL reset_rvld got=%b exp=0", rvld); end
    if (ridx !== 2'd0) begin failures++; $display("FAIL reset_ridx got=%0d exp=0", ridx); end
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks += 4;
      if (midx !== 2'(c)) begin failures++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", c, midx, c); end
      if (gnt !== 4'(1 << c)) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, gnt, 4'(1 << c)); end
      if (addr_o !== 32'h100 + c) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", c, addr_o, 32'h100 + c); end
      if (wdata_o !== 32'hD0 + c) begin failures++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", c, wdata_o, 32'hD0 + c); end
      step();
    end
    req = 4'b0;
    gnt_i = 1'b0;
    #1;
    checks += 2;
    if (rvld !== 1'b1) begin failures++; $display("FAIL rr_rvld got=%b exp=1", rvld); end
    if (ridx !== 2'd0) begin failures++; $display("FAIL rr_head got=%0d exp=0", ridx); end
  endtask

  task automatic test_full_write;
    req = 4'b0011;
    wen[1] = 1'b1;
    gnt_i = 1'b1;
    #1;
    checks += 3;
    if (midx !== 2'd1) begin failures++; $display("FAIL full_idx got=%0d exp=1", midx); end
    if (gnt !== 4'b0010) begin failures++; $display("FAIL full_gnt got=%b exp=0010", gnt); end
    if (wen_o !== 1'b1) begin failures++; $display("FAIL full_wen got=%b exp=1", wen_o); end
    step();
    wen[1] = 1'b0;
    req = 4'b0001;
    #1;
    checks += 3;
    if (req_o !== 1'b0) begin failures++; $display("FAIL full_block_req got=%b exp=0", req_o); end
    if (addr_o !== 32'h0) begin failures++; $display("FAIL full_block_addr got=%h exp=0", addr_o); end
    if (gnt !== 4'b0) begin failures++; $display("FAIL full_block_gnt got=%b exp=0000", gnt); end
    req = 4'b0;
    gnt_i = 1'b0;
    rvalid = 1'b1;
    rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks += 2;
      if (rvld !== 1'b1) begin failures++; $display("FAIL drain_rvld[%0d] got=%b exp=1", c, rvld); end
      if (ridx !== 2'(c)) begin failures++; $display("FAIL drain_head[%0d] got=%0d exp=%0d", c, ridx, c); end
      step();
    end
    rvalid = 1'b0;
    #1;
    checks++;
    if (rvld !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", rvld); end
  endtask

  task automatic test_push_pop;
    req = 4'b0100;
    gnt_i = 1'b1;
    step();
    req = 4'b1000;
    rvalid = 1'b1;
    #1;
    checks += 2;
    if (midx !== 2'd3) begin failures++; $display("FAIL pp_idx got=%0d exp=3", midx); end
    if (ridx !== 2'd2) begin failures++; $display("FAIL pp_head_before got=%0d exp=2", ridx); end
    step();
    req = 4'b0;
    gnt_i = 1'b0;
    #1;
    checks += 2;
    if (rvld !== 1'b1) begin failures++; $display("FAIL pp_rvld got=%b exp=1", rvld); end
    if (ridx !== 2'd3) begin failures++; $display("FAIL pp_head_after got=%0d exp=3", ridx); end
    step();
    rvalid = 1'b0;
    #1;
    checks++;
    if (rvld !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", rvld); end
  endtask

  task automatic test_lock;
    for (int i = 0; i < 4; i++) wen[i] = 1'b1;
    req = 4'b0101;
    gnt_i = 1'b0;
    #1;
    checks++;
    if (midx !== 2'd0) begin failures++; $display("FAIL lk_idx0 got=%0d exp=0", midx); end
    step();
`ifdef TCDM_REQ_MUX_LOCK_EN
    for (int c = 1; c < 3; c++) begin
      #1;
      checks += 2;
      if (midx !== 2'd0) begin failures++; $display("FAIL lk_hold_idx[%0d] got=%0d exp=0", c, midx); end
      if (addr_o !== 32'h100) begin failures++; $display("FAIL lk_hold_addr[%0d] got=%h exp=100", c, addr_o); end
      step();
    end
    gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL lk_acc_gnt got=%b exp=0001", gnt); end
    step();
    gnt_i = 1'b0;
    #1;
    checks++;
    if (midx !== 2'd2) begin failures++; $display("FAIL lk_next got=%0d exp=2", midx); end
`else
    req = 4'b0100;
    #1;
    checks += 2;
    if (midx !== 2'd2) begin failures++; $display("FAIL nl_switch got=%0d exp=2", midx); end
    if (addr_o !== 32'h102) begin failures++; $display("FAIL nl_addr got=%h exp=102", addr_o); end
    gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL nl_acc_gnt got=%b exp=0100", gnt); end
    step();
    gnt_i = 1'b0;
    req = 4'b0101;
    #1;
    checks++;
    if (midx !== 2'd0) begin failures++; $display("FAIL nl_wrap got=%0d exp=0", midx); end
`endif
    step();
    req = 4'b0;
    for (int i = 0; i < 4; i++) wen[i] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid;
    gnt_i = 1'b1;
    req = 4'b0001;
    step();
    req = 4'b0010;
    step();
    req = 4'b0;
    gnt_i = 1'b0;
    #1;
    checks += 2;
    if (rvld !== 1'b1) begin failures++; $display("FAIL rm_pre_rvld got=%b exp=1", rvld); end
    if (ridx !== 2'd0) begin failures++; $display("FAIL rm_pre_head got=%0d exp=0", ridx); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1001;
    #1;
    checks += 3;
    if (rvld !== 1'b0) begin failures++; $display("FAIL rm_rvld got=%b exp=0", rvld); end
    if (ridx !== 2'd0) begin failures++; $display("FAIL rm_head got=%0d exp=0", ridx); end
    if (midx !== 2'd0) begin failures++; $display("FAIL rm_rrptr got=%0d exp=0", midx); end
    req = 4'b0;
    rvalid = 1'b1;
    rready = 1'b1;
    step();
    rvalid = 1'b0;
    req = 4'b1000;
    gnt_i = 1'b1;
    step();
    req = 4'b0;
    gnt_i = 1'b0;
    #1;
    checks += 2;
    if (rvld !== 1'b1) begin failures++; $display("FAIL rm_post_rvld got=%b exp=1", rvld); end
    if (ridx !== 2'd3) begin failures++; $display("FAIL rm_post_head got=%0d exp=3", ridx); end
  endtask

  initial begin
    req = 4'b0;
    gnt_i = 1'b0;
    rvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h100 + i;
      wen[i] = 1'b0;
      wdata[i] = 32'hD0 + i;
      be[i] = 4'hF;
    end
    test_reset();
    test_round_robin();
    test_full_write();
    test_push_pop();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
